uart_fc_core: RTL and testbench

Parametrised UART core with 16x-oversampled receive, an RX FIFO and RTS/CTS hardware flow control toward the USB bridge. It replaces the fixed 8N1/115200 UART wrapper: frame format, baud rate and FIFO depth are parameters, and received bytes are buffered behind a valid/ready stream. It sits between the USB-UART pins and FPGA fabric logic. The fabric side uses valid/ready handshakes in both directions.

---
 rtl/uart_fc_core_if.sv | 24 ++
 rtl/uart_fc_core.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_fc_core.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fc_core_if.sv
// uart_fc_core_if: fabric-side TX/RX valid/ready streams and RX status pulses of uart_fc_core.
interface uart_fc_core_if #(
    parameter int DATA_BITS = 8,
    parameter int RX_DEPTH  = 16
);
    logic [DATA_BITS-1:0]      tx_data;
    logic                      tx_valid;
    logic                      tx_ready;
    logic [DATA_BITS-1:0]      rx_data;
    logic                      rx_valid;
    logic                      rx_ready;
    logic [$clog2(RX_DEPTH):0] rx_level;
    logic                      rx_frame_err;
    logic                      rx_overrun;
    logic                      rx_parity_err;
    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid, rx_level, rx_frame_err, rx_overrun, rx_parity_err
    );
    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid, rx_level, rx_frame_err, rx_overrun, rx_parity_err
    );
endinterface

// File: rtl/uart_fc_core.sv
// uart_fc_core: UART with 16x oversampled RX, RX FIFO and RTS/CTS flow control.
// Define UART_PARITY_EN to add an even parity bit on TX and parity checking on RX.
module uart_fc_core #(
    parameter int CLK_HZ    = 27000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int RX_DEPTH  = 16
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic rx,
    input  logic rts_n,
    output logic tx,
    output logic cts_n,
    uart_fc_core_if.slave bus
);
    localparam int DIV_R = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
    localparam int DIV   = DIV_R < 1 ? 1 : DIV_R;
    localparam int CW    = $clog2(DIV + 1);
    localparam int AW    = $clog2(RX_DEPTH);
    localparam int BW    = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        T_IDLE, T_START, T_DATA,
`ifdef UART_PARITY_EN
        T_PAR,
`endif
        T_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA,
`ifdef UART_PARITY_EN
        R_PAR,
`endif
        R_STOP, R_WAIT
    } rx_state_t;

`ifdef UART_PARITY_EN
    localparam tx_state_t T_LAST = T_PAR;
    localparam rx_state_t R_LAST = R_PAR;
`else
    localparam tx_state_t T_LAST = T_STOP;
    localparam rx_state_t R_LAST = R_STOP;
`endif

    logic [CW-1:0] div_cnt;
    logic          tick;
    logic [1:0]    rx_sync, rts_sync;
    logic          rx_s, rx_p, rts_s;

    assign tick  = div_cnt == CW'(DIV - 1);
    assign rx_s  = rx_sync[1];
    assign rts_s = rts_sync[1];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt  <= '0;
            rx_sync  <= 2'b11;
            rts_sync <= 2'b11;
            rx_p     <= 1'b1;
        end else begin
            div_cnt  <= tick ? '0 : div_cnt + 1'b1;
            rx_sync  <= {rx_sync[0], rx};
            rts_sync <= {rts_sync[0], rts_n};
            rx_p     <= rx_s;
        end
    end

    tx_state_t            tx_st, tx_nx;
    logic [3:0]           tx_tc;
    logic [BW-1:0]        tx_bc;
    logic [DATA_BITS-1:0] tx_sh;
    logic                 tx_bit, tx_end, accept;
`ifdef UART_PARITY_EN
    logic                 tx_par;
`endif

    assign accept = bus.tx_valid & bus.tx_ready;
    assign tx_end = tick && tx_tc == 4'd15;

    always_comb begin
        tx_nx  = tx_st;
        tx_bit = 1'b1;
        case (tx_st)
            T_IDLE:  tx_nx = accept ? T_START : T_IDLE;
            T_START: begin
                tx_bit = 1'b0;
                tx_nx  = tx_end ? T_DATA : T_START;
            end
            T_DATA:  begin
                tx_bit = tx_sh[0];
                tx_nx  = tx_end && tx_bc == BW'(DATA_BITS - 1) ? T_LAST : T_DATA;
            end
`ifdef UART_PARITY_EN
            T_PAR:   begin
                tx_bit = tx_par;
                tx_nx  = tx_end ? T_STOP : T_PAR;
            end
`endif
            T_STOP:  tx_nx = tx_end && tx_bc == BW'(STOP_BITS - 1) ? T_IDLE : T_STOP;
            default: tx_nx = T_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) tx_st <= T_IDLE;
        else tx_st <= tx_nx;

    // tx is re-registered on every tick so the start bit begins on a tick boundary
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx           <= 1'b1;
            tx_tc        <= '0;
            tx_bc        <= '0;
            tx_sh        <= '0;
            bus.tx_ready <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par       <= 1'b0;
`endif
        end else begin
            bus.tx_ready <= tx_nx == T_IDLE && !rts_s;
            if (tick) tx <= tx_bit;
            if (accept) begin
                tx_sh <= bus.tx_data;
                tx_tc <= '0;
                tx_bc <= '0;
`ifdef UART_PARITY_EN
                tx_par <= ^bus.tx_data;
`endif
            end else if (tick) begin
                tx_tc <= tx_tc + 4'd1;
                if (tx_end) tx_bc <= tx_nx != tx_st ? '0 : tx_bc + 1'b1;
                if (tx_end && tx_st == T_DATA) tx_sh <= tx_sh >> 1;
            end
        end
    end

    rx_state_t            rx_st, rx_nx;
    logic [3:0]           rx_tc;
    logic [BW-1:0]        rx_bc;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 rx_perr, mid, stop_smp, push, pop, full;
    logic [DATA_BITS-1:0] mem [RX_DEPTH];
    logic [AW:0]          wp, rp;

    assign mid      = tick && rx_tc == 4'd15;
    assign stop_smp = rx_st == R_STOP && mid;
    assign push     = stop_smp && rx_s && !rx_perr;

    always_comb begin
        rx_nx = rx_st;
        case (rx_st)
            R_IDLE:  rx_nx = rx_p && !rx_s ? R_START : R_IDLE;
            R_START: rx_nx = tick && rx_tc == 4'd7 ? (rx_s ? R_IDLE : R_DATA) : R_START;
            R_DATA:  rx_nx = mid && rx_bc == BW'(DATA_BITS - 1) ? R_LAST : R_DATA;
`ifdef UART_PARITY_EN
            R_PAR:   rx_nx = mid ? R_STOP : R_PAR;
`endif
            R_STOP:  rx_nx = mid ? (rx_s ? R_IDLE : R_WAIT) : R_STOP;
            R_WAIT:  rx_nx = rx_s ? R_IDLE : R_WAIT;
            default: rx_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) rx_st <= R_IDLE;
        else rx_st <= rx_nx;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_tc            <= '0;
            rx_bc            <= '0;
            rx_sh            <= '0;
            rx_perr          <= 1'b0;
            bus.rx_frame_err <= 1'b0;
            bus.rx_overrun   <= 1'b0;
        end else begin
            bus.rx_frame_err <= stop_smp && !rx_s;
            bus.rx_overrun   <= push && full;
            if (rx_st == R_IDLE) begin
                rx_tc   <= '0;
                rx_bc   <= '0;
                rx_perr <= 1'b0;
            end else if (tick) begin
                rx_tc <= rx_st == R_START && rx_tc == 4'd7 ? 4'd0 : rx_tc + 4'd1;
                if (mid && rx_st == R_DATA) begin
                    rx_sh <= {rx_s, rx_sh[DATA_BITS-1:1]};
                    rx_bc <= rx_bc + 1'b1;
                end
`ifdef UART_PARITY_EN
                if (mid && rx_st == R_PAR) rx_perr <= rx_s != ^rx_sh;
`endif
            end
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) bus.rx_parity_err <= 1'b0;
        else bus.rx_parity_err <= stop_smp && rx_perr;
`else
    assign bus.rx_parity_err = 1'b0;
`endif

    // fullness is judged before any same-cycle pop, so push-while-full is an overrun
    assign bus.rx_level = wp - rp;
    assign bus.rx_valid = wp != rp;
    assign bus.rx_data  = mem[rp[AW-1:0]];
    assign full         = bus.rx_level == (AW + 1)'(RX_DEPTH);
    assign pop          = bus.rx_valid & bus.rx_ready;

    always_ff @(posedge sys_clk)
        if (push && !full) mem[wp[AW-1:0]] <= rx_sh;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wp    <= '0;
            rp    <= '0;
            cts_n <= 1'b1;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cts_n <= bus.rx_level >= (AW + 1)'(RX_DEPTH - 2) ? 1'b1 :
                     bus.rx_level <= (AW + 1)'(RX_DEPTH - 4) ? 1'b0 : cts_n;
        end
    end
endmodule

// File: tb/tb_uart_fc_core.sv
// tb_uart_fc_core: directed checks of TX framing, RTS gating, RX sampling, FIFO, CTS hysteresis and reset.
module tb_uart_fc_core;
    localparam int CLK_HZ = 1843200;
    localparam int BAUD   = 115200;
    localparam int DB     = 8;
    localparam int DEPTH  = 16;
`ifdef UART_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB = 2 + DB + P;

    logic sys_clk = 1'b0, sys_rst_n = 1'b0, rx = 1'b1, rts_n = 1'b0;
    logic tx, cts_n;
    int   n_chk = 0, n_pass = 0;
    int   lvl_at, n_fe, n_ov, n_pe;

    uart_fc_core_if #(.DATA_BITS(DB), .RX_DEPTH(DEPTH)) bus ();

    uart_fc_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DB), .STOP_BITS(1), .RX_DEPTH(DEPTH)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx), .rts_n(rts_n),
        .tx(tx), .cts_n(cts_n), .bus(bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // drive one serial frame on rx and record when rx_level first grows and any status pulses
    task automatic send_rx(input logic [7:0] d, input logic stop, input logic flip);
        logic [10:0] fr;
        logic [4:0]  prev;
        fr = (P != 0) ? {stop, ^d ^ flip, d, 1'b0} : {1'b1, stop, d, 1'b0};
        lvl_at = -1; n_fe = 0; n_ov = 0; n_pe = 0;
        for (int c = 0; c < NB * 16 + 8; c++) begin
            prev = bus.rx_level;
            rx = c < NB * 16 ? fr[c/16] : 1'b1;
            step(1);
            if (bus.rx_level > prev && lvl_at < 0) lvl_at = c + 1;
            if (bus.rx_frame_err) n_fe++;
            if (bus.rx_overrun) n_ov++;
            if (bus.rx_parity_err) n_pe++;
        end
    endtask

    task automatic test_reset;
        step(2);
        n_chk++; if ({tx, cts_n, bus.tx_ready, bus.rx_valid} !== 4'b1100) $display("FAIL reset_outs: got %b want 1100", {tx, cts_n, bus.tx_ready, bus.rx_valid}); else n_pass++;
        n_chk++; if ({bus.rx_level, bus.rx_frame_err, bus.rx_overrun, bus.rx_parity_err} !== 8'h00) $display("FAIL reset_level: got %h want 00", {bus.rx_level, bus.rx_frame_err, bus.rx_overrun, bus.rx_parity_err}); else n_pass++;
        sys_rst_n = 1'b1;
        step(1);
        n_chk++; if (cts_n !== 1'b0) $display("FAIL cts_after_release: got %b want 0", cts_n); else n_pass++;
        n_chk++; if (bus.tx_ready !== 1'b0) $display("FAIL tx_ready_c1: got %b want 0", bus.tx_ready); else n_pass++;
        step(1);
        n_chk++; if (bus.tx_ready !== 1'b0) $display("FAIL tx_ready_c2: got %b want 0", bus.tx_ready); else n_pass++;
        step(1);
        n_chk++; if (bus.tx_ready !== 1'b1) $display("FAIL tx_ready_c3: got %b want 1", bus.tx_ready); else n_pass++;
    endtask

    task automatic test_tx;
        logic [7:0]  d;
        logic [10:0] fr;
        d = 8'hA5;
        fr = (P != 0) ? {1'b1, ^d, d, 1'b0} : {2'b11, d, 1'b0};
        bus.tx_data = d;
        bus.tx_valid = 1'b1;
        step(1);
        bus.tx_valid = 1'b0;
        n_chk++; if ({bus.tx_ready, tx} !== 2'b01) $display("FAIL tx_accept: got %b want 01", {bus.tx_ready, tx}); else n_pass++;
        for (int c = 1; c <= NB * 16; c++) begin
            step(1);
            n_chk++; if (tx !== fr[(c-1)/16]) $display("FAIL tx_bit c=%0d: got %b want %b", c, tx, fr[(c-1)/16]); else n_pass++;
            if (c == NB * 16 - 1) begin
                n_chk++; if (bus.tx_ready !== 1'b0) $display("FAIL tx_ready_busy: got %b want 0", bus.tx_ready); else n_pass++;
            end
        end
        n_chk++; if (bus.tx_ready !== 1'b1) $display("FAIL tx_ready_done: got %b want 1", bus.tx_ready); else n_pass++;
    endtask

    task automatic test_flow;
        logic [7:0]  d;
        logic [10:0] fr;
        d = 8'h5A;
        fr = (P != 0) ? {1'b1, ^d, d, 1'b0} : {2'b11, d, 1'b0};
        rts_n = 1'b1;
        step(4);
        n_chk++; if (bus.tx_ready !== 1'b0) $display("FAIL rts_block_ready: got %b want 0", bus.tx_ready); else n_pass++;
        bus.tx_data = d;
        bus.tx_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step(1);
            n_chk++; if ({bus.tx_ready, tx} !== 2'b01) $display("FAIL rts_hold c=%0d: got %b want 01", c, {bus.tx_ready, tx}); else n_pass++;
        end
        rts_n = 1'b0;
        step(3);
        n_chk++; if (bus.tx_ready !== 1'b1) $display("FAIL rts_release_ready: got %b want 1", bus.tx_ready); else n_pass++;
        step(1);
        bus.tx_data = 8'hC3;
        step(69);
        rts_n = 1'b1;
        for (int c = 71; c <= NB * 16 + 40; c++) begin
            step(1);
            if (c % 16 == 8 && c < NB * 16) begin
                n_chk++; if (tx !== fr[c/16]) $display("FAIL flow_bit c=%0d: got %b want %b", c, tx, fr[c/16]); else n_pass++;
            end
            if (c == NB * 16 || c == NB * 16 + 40) begin
                n_chk++; if ({bus.tx_ready, tx} !== 2'b01) $display("FAIL flow_no_accept c=%0d: got %b want 01", c, {bus.tx_ready, tx}); else n_pass++;
            end
        end
        bus.tx_valid = 1'b0;
        rts_n = 1'b0;
        step(4);
        n_chk++; if (bus.tx_ready !== 1'b1) $display("FAIL flow_resume: got %b want 1", bus.tx_ready); else n_pass++;
    endtask

    task automatic test_rx;
        send_rx(8'h3C, 1'b1, 1'b0);
        n_chk++; if (lvl_at !== 155 + 16 * P) $display("FAIL rx_latency: got %0d want %0d", lvl_at, 155 + 16 * P); else n_pass++;
        n_chk++; if ({bus.rx_valid, bus.rx_data} !== 9'h13C) $display("FAIL rx_byte: got %h want 13c", {bus.rx_valid, bus.rx_data}); else n_pass++;
        n_chk++; if (n_fe + n_ov + n_pe !== 0) $display("FAIL rx_flags: got %0d want 0", n_fe + n_ov + n_pe); else n_pass++;
        bus.rx_ready = 1'b1;
        step(1);
        bus.rx_ready = 1'b0;
        n_chk++; if ({bus.rx_valid, bus.rx_level} !== 6'h00) $display("FAIL rx_pop: got %h want 00", {bus.rx_valid, bus.rx_level}); else n_pass++;
    endtask

    task automatic test_glitch;
        int flags;
        flags = 0;
        for (int c = 0; c < 40; c++) begin
            rx = c < 4 ? 1'b0 : 1'b1;
            step(1);
            if (bus.rx_frame_err || bus.rx_overrun || bus.rx_parity_err || bus.rx_valid) flags++;
        end
        n_chk++; if (flags !== 0) $display("FAIL glitch_events: got %0d want 0", flags); else n_pass++;
        n_chk++; if (bus.rx_level !== 5'd0) $display("FAIL glitch_level: got %0d want 0", bus.rx_level); else n_pass++;
        send_rx(8'h00, 1'b1, 1'b0);
        n_chk++; if (lvl_at !== 155 + 16 * P) $display("FAIL after_glitch_rx: got %0d want %0d", lvl_at, 155 + 16 * P); else n_pass++;
        bus.rx_ready = 1'b1;
        step(1);
        bus.rx_ready = 1'b0;
    endtask

    task automatic test_fifo;
        int tot_ov;
        tot_ov = 0;
        for (int i = 0; i < 14; i++) begin
            send_rx(8'h10 + 8'(i), 1'b1, 1'b0);
            if (i == 12) begin
                n_chk++; if ({bus.rx_level, cts_n} !== {5'd13, 1'b0}) $display("FAIL level13: got %h want 1a", {bus.rx_level, cts_n}); else n_pass++;
            end
        end
        n_chk++; if ({bus.rx_level, cts_n} !== {5'd14, 1'b1}) $display("FAIL level14_cts: got %h want 1d", {bus.rx_level, cts_n}); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            send_rx(8'h1E + 8'(i), 1'b1, 1'b0);
            tot_ov += n_ov;
        end
        n_chk++; if (bus.rx_level !== 5'd16) $display("FAIL full_level: got %0d want 16", bus.rx_level); else n_pass++;
        n_chk++; if (tot_ov !== 1) $display("FAIL overrun_count: got %0d want 1", tot_ov); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (bus.rx_data !== 8'h10 + 8'(i)) $display("FAIL pop_data i=%0d: got %h want %h", i, bus.rx_data, 8'h10 + 8'(i)); else n_pass++;
            bus.rx_ready = 1'b1;
            step(1);
            bus.rx_ready = 1'b0;
        end
        n_chk++; if ({bus.rx_level, cts_n} !== {5'd12, 1'b1}) $display("FAIL level12_hold: got %h want 19", {bus.rx_level, cts_n}); else n_pass++;
        step(1);
        n_chk++; if (cts_n !== 1'b0) $display("FAIL cts_release: got %b want 0", cts_n); else n_pass++;
    endtask

    task automatic test_errors;
        send_rx(8'h77, 1'b0, 1'b0);
        n_chk++; if (n_fe !== 1) $display("FAIL frame_err_pulse: got %0d want 1", n_fe); else n_pass++;
        n_chk++; if ({lvl_at, 27'd0, bus.rx_level} !== {-32'sd1, 27'd0, 5'd12}) $display("FAIL frame_err_level: got %0d/%0d want -1/12", lvl_at, bus.rx_level); else n_pass++;
        n_chk++; if (n_pe !== 0) $display("FAIL frame_err_parity: got %0d want 0", n_pe); else n_pass++;
`ifdef UART_PARITY_EN
        send_rx(8'h77, 1'b1, 1'b1);
        n_chk++; if (n_pe !== 1) $display("FAIL parity_pulse: got %0d want 1", n_pe); else n_pass++;
        n_chk++; if (bus.rx_level !== 5'd12) $display("FAIL parity_drop: got %0d want 12", bus.rx_level); else n_pass++;
`endif
        send_rx(8'h99, 1'b1, 1'b0);
        n_chk++; if ({bus.rx_level, n_fe[3:0]} !== {5'd13, 4'd0}) $display("FAIL recover: got %0d/%0d want 13/0", bus.rx_level, n_fe); else n_pass++;
    endtask

    task automatic test_reset_mid;
        bus.rx_ready = 1'b1;
        step(8);
        bus.rx_ready = 1'b0;
        n_chk++; if ({bus.rx_valid, bus.rx_level} !== {1'b1, 5'd5}) $display("FAIL five_bytes: got %h want 25", {bus.rx_valid, bus.rx_level}); else n_pass++;
        bus.tx_data = 8'h81;
        bus.tx_valid = 1'b1;
        step(1);
        bus.tx_valid = 1'b0;
        step(40);
        n_chk++; if (tx !== 1'b0) $display("FAIL mid_frame_tx: got %b want 0", tx); else n_pass++;
        sys_rst_n = 1'b0;
        #1;
        n_chk++; if ({tx, cts_n, bus.rx_valid} !== 3'b110) $display("FAIL async_reset_outs: got %b want 110", {tx, cts_n, bus.rx_valid}); else n_pass++;
        n_chk++; if (bus.rx_level !== 5'd0) $display("FAIL async_reset_level: got %0d want 0", bus.rx_level); else n_pass++;
        step(1);
        sys_rst_n = 1'b1;
        step(1);
        n_chk++; if (cts_n !== 1'b0) $display("FAIL rerelease_cts: got %b want 0", cts_n); else n_pass++;
        step(2);
        n_chk++; if ({bus.tx_ready, tx} !== 2'b11) $display("FAIL rerelease_ready: got %b want 11", {bus.tx_ready, tx}); else n_pass++;
    endtask

    initial begin
        bus.tx_data = '0;
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b0;
        test_reset;
        test_tx;
        test_flow;
        test_rx;
        test_glitch;
        test_fifo;
        test_errors;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end
endmodule
